// File: rtl/scoreboard_if.sv
// Types shared by decode, the functional units, commit and the scoreboard,
// plus the interface bundling every scoreboard signal except clock/reset.
package sb_pkg;

    localparam int NR_SB_ENTRIES = 4;
    localparam int NR_WB_PORTS   = 2;
    localparam int TRANS_ID_BITS = 2;

    localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

    typedef struct packed {
        logic [63:0] cause;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// Handshakes: decode presents an entry with decoded_instr_valid_i and it is
// taken on any clock edge where decoded_instr_ack_o is also high; the
// scoreboard presents the head with commit_valid_o and it is retired on any
// clock edge where commit_ack_i is also high. Writebacks are one-cycle
// strobes with no back-pressure.
interface scoreboard_if #(
    parameter int NR_WB   = sb_pkg::NR_WB_PORTS,
    parameter int ID_BITS = sb_pkg::TRANS_ID_BITS
) ();
    import sb_pkg::*;

    logic                    flush_i;
    logic                    full_o;
    scoreboard_entry_t       decoded_instr_i;
    logic                    decoded_instr_valid_i;
    logic                    decoded_instr_ack_o;
    logic [ID_BITS-1:0]      alloc_trans_id_o;
    logic [ID_BITS-1:0]      wb_trans_id_i [NR_WB];
    logic [63:0]             wb_data_i [NR_WB];
    exception_t              wb_ex_i [NR_WB];
    logic [NR_WB-1:0]        wb_valid_i;
    scoreboard_entry_t       commit_instr_o;
    logic                    commit_valid_o;
    logic                    commit_ack_i;
    logic [4:0]              rs1_i;
    logic [4:0]              rs2_i;
    logic                    rs1_busy_o;
    logic                    rs2_busy_o;
    logic                    rs1_fwd_valid_o;
    logic                    rs2_fwd_valid_o;
    logic [63:0]             rs1_o;
    logic [63:0]             rs2_o;

    modport slave (
        input  flush_i, decoded_instr_i, decoded_instr_valid_i,
               wb_trans_id_i, wb_data_i, wb_ex_i, wb_valid_i,
               commit_ack_i, rs1_i, rs2_i,
        output full_o, decoded_instr_ack_o, alloc_trans_id_o,
               commit_instr_o, commit_valid_o,
               rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o,
               rs1_o, rs2_o
    );

    modport master (
        output flush_i, decoded_instr_i, decoded_instr_valid_i,
               wb_trans_id_i, wb_data_i, wb_ex_i, wb_valid_i,
               commit_ack_i, rs1_i, rs2_i,
        input  full_o, decoded_instr_ack_o, alloc_trans_id_o,
               commit_instr_o, commit_valid_o,
               rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o,
               rs1_o, rs2_o
    );

endinterface

// File: rtl/scoreboard.sv
// In-order tracking buffer between issue and commit: allocates a trans_id
// per decoded instruction, absorbs out-of-order writebacks, retires the
// oldest completed entry and answers operand busy/forwarding queries.
module scoreboard #(
    parameter int NR_ENTRIES = sb_pkg::NR_SB_ENTRIES,
    parameter int NR_WB      = sb_pkg::NR_WB_PORTS,
    parameter int ID_BITS    = sb_pkg::TRANS_ID_BITS
) (
    input  logic          clk_i,
    input  logic          rst_i,
    scoreboard_if.slave   sb
);
    import sb_pkg::*;

    localparam logic [ID_BITS-1:0] PTR_ONE = ID_BITS'(1);
    localparam logic [ID_BITS:0]   CNT_ONE = (ID_BITS+1)'(1);
    localparam logic [ID_BITS:0]   CNT_FULL = (ID_BITS+1)'(NR_ENTRIES);

    scoreboard_entry_t     r_mem [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] r_occ;
    logic [ID_BITS-1:0]    r_head;
    logic [ID_BITS-1:0]    r_tail;
    logic [ID_BITS:0]      r_count;
    logic                  r_full;

    logic                  w_ack;
    logic                  w_commit_valid;
    logic                  w_commit;
    logic [ID_BITS:0]      w_count_next;
    scoreboard_entry_t     w_new_entry;
    logic [4:0]            w_rs    [2];
    logic                  w_busy  [2];
    logic                  w_fwd   [2];
    logic [63:0]           w_data  [2];

    // full is registered, so a same-cycle commit never frees a slot for
    // the allocation presented in that cycle.
    assign w_ack          = sb.decoded_instr_valid_i && !r_full;
    assign w_commit_valid = (r_count != '0) && r_mem[r_head].valid;
    assign w_commit       = w_commit_valid && sb.commit_ack_i;

    assign w_rs[0] = sb.rs1_i;
    assign w_rs[1] = sb.rs2_i;

    // Entry as stored: id is the tail slot, an entry already carrying an
    // exception from decode is complete on arrival.
    always_comb begin
        w_new_entry          = sb.decoded_instr_i;
        w_new_entry.trans_id = r_tail;
        w_new_entry.valid    = sb.decoded_instr_i.ex.valid;
    end

    // Occupancy after this cycle's allocation and commit.
    always_comb begin
        w_count_next = r_count;
        if (w_ack && !w_commit) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!w_ack && w_commit) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    // Buffer state: reset/flush clear everything, otherwise apply
    // writebacks, then commit, then allocation.
    always_ff @(posedge clk_i) begin
        if (rst_i || sb.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_occ   <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else begin
            // Later ports overwrite earlier ones when two target one id.
            for (int p = 0; p < NR_WB; p++) begin
                if (sb.wb_valid_i[p] && r_occ[sb.wb_trans_id_i[p]] &&
                    !(w_ack && (sb.wb_trans_id_i[p] == r_tail))) begin
                    r_mem[sb.wb_trans_id_i[p]].result <= sb.wb_data_i[p];
                    r_mem[sb.wb_trans_id_i[p]].valid  <= 1'b1;
                    if (sb.wb_ex_i[p].valid) begin
                        r_mem[sb.wb_trans_id_i[p]].ex <= sb.wb_ex_i[p];
                    end
                end
            end
            if (w_commit) begin
                r_occ[r_head]       <= 1'b0;
                r_mem[r_head].valid <= 1'b0;
                r_head              <= r_head + PTR_ONE;
            end
            if (w_ack) begin
                r_mem[r_tail] <= w_new_entry;
                r_occ[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_FULL);
        end
    end

    // Operand lookup: walk from head towards tail so the youngest matching
    // writer is the one left selected.
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            w_busy[q] = 1'b0;
            w_fwd[q]  = 1'b0;
            w_data[q] = '0;
            for (int k = 0; k < NR_ENTRIES; k++) begin
                logic [ID_BITS-1:0] idx;
                idx = r_head + ID_BITS'(k);
                if (r_occ[idx] && (r_mem[idx].rd == w_rs[q]) && (w_rs[q] != 5'd0)) begin
                    w_busy[q] = 1'b1;
                    w_fwd[q]  = r_mem[idx].valid;
                    w_data[q] = r_mem[idx].result;
                end
            end
        end
    end

    assign sb.full_o              = r_full;
    assign sb.decoded_instr_ack_o = w_ack;
    assign sb.alloc_trans_id_o    = r_tail;
    assign sb.commit_instr_o      = r_mem[r_head];
    assign sb.commit_valid_o      = w_commit_valid;
    assign sb.rs1_busy_o          = w_busy[0];
    assign sb.rs2_busy_o          = w_busy[1];
    assign sb.rs1_fwd_valid_o     = w_fwd[0];
    assign sb.rs2_fwd_valid_o     = w_fwd[1];
    assign sb.rs1_o               = w_data[0];
    assign sb.rs2_o               = w_data[1];

endmodule
